mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 122 ++++++++++++
 tb/tb_mult_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: a two-state FSM with a latency down-counter;
// results are written to hi/lo on the last busy cycle unless cancelled.
module mult_div_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [2:0] {
    OP_MULTU = 3'd0, OP_MULT = 3'd1, OP_DIVU = 3'd2,
    OP_DIV   = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5
  } op_e;

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;        // bit 0: signed, bit 1: divide
  logic               accept;
  logic               accept_md;
  logic               last;

  assign accept    = start && !cancel && (state == IDLE);
  assign accept_md = accept && (op[2] == 1'b0);
  assign last      = (state == BUSY) && !cancel && (cnt == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned
  // and a latch cannot be inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_md)          state_next = BUSY;
      BUSY: if (cancel || cnt == CNT_W'(1)) state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
  end

  // NOTE: operand capture registers carry no reset; they are only read while
  // BUSY, which is always entered through a fresh capture.
  always_ff @(posedge clk) begin
    if (accept_md) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op[1:0];
    end
  end

  // Result datapath: full-width product and magnitude-based division.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    a_ext = op_q[0] ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = op_q[0] ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;

    a_neg  = op_q[0] & a_q[WIDTH-1];
    b_neg  = op_q[0] & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    // Min-negative / -1 yields a magnitude of 2^(WIDTH-1), which wraps to itself.
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (accept_md) begin
        cnt <= op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end else if (state == BUSY) begin
        cnt <= (cancel || cnt == CNT_W'(1)) ? '0 : cnt - CNT_W'(1);
      end

      if (accept && op == OP_MTHI) hi <= a;
      if (accept && op == OP_MTLO) lo <= a;

      if (last) begin
        if (!op_q[1]) begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end else if (b_q != '0) begin
          hi <= rem;
          lo <= quot;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic model
// of HI/LO built on 64-bit integer math.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic         clk = 1'b0;
  logic         reset, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_hi, exp_lo;

  mult_div_unit #(.WIDTH(W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".busy"}, {31'b0, busy}, 32'd0);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
  endtask

  // Reference result of an operation applied to the current (hi, lo) pair.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       inout logic [W-1:0] mh, inout logic [W-1:0] ml);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; mh = p[63:32]; ml = p[31:0]; end
      3'd1: begin p = 64'(sx * sy); mh = p[63:32]; ml = p[31:0]; end
      3'd2: if (y != 0) begin ml = x / y; mh = x % y; end
      3'd3: if (y != 0) begin q = sx / sy; r = sx % sy; ml = q[31:0]; mh = r[31:0]; end
      3'd4: mh = x;
      3'd5: ml = x;
      default: ;
    endcase
  endtask

  // Issue one op; optionally cancel on busy cycle cancel_c, or fire a stray
  // start on busy cycle 2.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int cancel_c, input bit stray);
    int lat;
    logic [W-1:0] nh, nl;
    nh = exp_hi;
    nl = exp_lo;
    model(o, x, y, nh, nl);
    lat = (o <= 3'd1) ? MULT_LAT : (o <= 3'd3) ? DIV_LAT : 0;
    start = 1'b1; op = o; a = x; b = y; cancel = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    for (int c = 1; c <= lat; c++) begin
      check({tag, ".busy_on"}, {31'b0, busy}, 32'd1);
      if (c == cancel_c) cancel = 1'b1;
      if (stray && c == 2) start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (cancel) begin
        cancel = 1'b0;
        check_regs({tag, ".cancel"});
        return;
      end
    end
    exp_hi = nh;
    exp_lo = nl;
    check_regs(tag);
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic [2:0]   o;
    int           cc;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_regs("reset");

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    run_op("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("mthi", 3'd4, 32'h1234, 32'd0, 0, 0);
    run_op("mtlo", 3'd5, 32'h5678, 32'd0, 0, 0);
    run_op("divu_zero", 3'd2, 32'd99, 32'd0, 0, 0);
    check("divu_zero.hi_abs", hi, 32'h1234);
    check("divu_zero.lo_abs", lo, 32'h5678);
    run_op("multu_cancel", 3'd0, 32'd3, 32'd4, 3, 0);
    run_op("multu_cancel_last", 3'd0, 32'd3, 32'd4, MULT_LAT, 0);
    run_op("multu_stray", 3'd0, 32'd3, 32'd4, 0, 1);
    check("multu_stray.lo_abs", lo, 32'd12);
    run_op("reserved", 3'd6, 32'hDEAD_BEEF, 32'd1, 0, 0);
    run_op("back2back", 3'd5, 32'hAAAA_0000, 32'd0, 0, 0);

    // start together with cancel in IDLE is suppressed
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; cancel = 1'b1; op = (i == 0) ? 3'd4 : 3'd1; a = 32'h0BAD_0BAD; b = 32'd7;
      @(posedge clk); @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      check_regs("idle_cancel");
    end

    // reset on busy cycle 2 discards the operation
    run_op("pre_reset", 3'd4, 32'h55, 32'd0, 0, 0);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_regs("reset_busy");
    for (int i = 0; i < MULT_LAT + 1; i++) begin
      @(posedge clk); @(negedge clk);
    end
    check_regs("reset_busy_after");

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: x = 32'h8000_0000;
        1: x = $urandom_range(0, 20);
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = $urandom_range(1, 9);
        default: y = $urandom;
      endcase
      cc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DIV_LAT) : 0;
      run_op("rand", o, x, y, cc, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
